// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, FSM states,
// instruction field positions and the decoder's output bundle.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU_R = 4'h1;
    localparam logic [3:0] OP_BZ    = 4'h2;
    localparam logic [3:0] OP_BC    = 4'h3;
    localparam logic [3:0] OP_BV    = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'h6;
    localparam logic [3:0] OP_RSVD  = 4'h7;

    localparam int OP_LSB   = 12;
    localparam int RS_LSB   = 9;
    localparam int RT_LSB   = 6;
    localparam int RD_R_LSB = 3;
    localparam int RD_I_LSB = 6;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [2:0] alu_op;
        logic [5:0] imm;
        logic       select_imm;
        logic       is_alu;
        logic       br_z;
        logic       br_c;
        logic       br_v;
        logic       is_jmp;
        logic       is_halt;
        logic       is_illegal;
        logic [7:0] off8;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder. Register/immediate fields are zero for
// anything that is not an ALU op, so the top only has to gate on state.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decode_t            dec
);

    logic [3:0] op;

    assign op = instr[INSTR_W-1:OP_LSB];

    always_comb begin
        dec      = '0;
        dec.off8 = instr[7:0];
        if (op[3]) begin
            // Opcodes 8..F: ALU with immediate, operation taken from op[2:0].
            dec.rs         = instr[RS_LSB+:3];
            dec.rd         = instr[RD_I_LSB+:3];
            dec.imm        = instr[5:0];
            dec.alu_op     = op[2:0];
            dec.select_imm = 1'b1;
            dec.is_alu     = 1'b1;
        end else begin
            case (op)
                OP_ALU_R: begin
                    dec.rs     = instr[RS_LSB+:3];
                    dec.rt     = instr[RT_LSB+:3];
                    dec.rd     = instr[RD_R_LSB+:3];
                    dec.alu_op = instr[2:0];
                    dec.is_alu = 1'b1;
                end
                OP_BZ:   dec.br_z       = 1'b1;
                OP_BC:   dec.br_c       = 1'b1;
                OP_BV:   dec.br_v       = 1'b1;
                OP_JMP:  dec.is_jmp     = 1'b1;
                OP_HALT: dec.is_halt    = 1'b1;
                OP_RSVD: dec.is_illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_control.sv
// Fetch/decode/sequencing stage: owns the PC, the two-cycle FETCH/EXEC FSM,
// the stored ALU flags and the retired-instruction counter.
module fetch_control
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               carry,
    input  logic               overflow,
    input  logic               zero,
    output logic [5:0]         immidiate,
    output logic               select_imm,
    output logic [2:0]         rs,
    output logic [2:0]         rt,
    output logic [2:0]         rd,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic               halted,
    output logic               illegal,
    output logic [15:0]        instret
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;
    logic            flag_c;
    logic            flag_v;
    logic            flag_z;
    logic            take_branch;
    logic            in_exec;
    decode_t         dec;

    instr_decoder u_decoder (
        .instr (imem_data),
        .dec   (dec)
    );

    assign in_exec     = (state == EXEC);
    assign pc_inc      = pc + PC_W'(1);
    assign off_ext     = PC_W'(signed'(dec.off8));
    assign take_branch = (dec.br_z & flag_z) | (dec.br_c & flag_c) | (dec.br_v & flag_v);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (dec.is_halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FETCH;
                    if (dec.is_jmp)
                        pc_nxt = imem_data[PC_W-1:0];
                    else if (take_branch)
                        pc_nxt = pc_inc + off_ext;
                    else
                        pc_nxt = pc_inc;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_z  <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (in_exec) begin
                if (dec.is_alu)
                    {flag_c, flag_v, flag_z} <= {carry, overflow, zero};
                if (dec.is_illegal)
                    illegal <= 1'b1;
                if (instret != 16'hFFFF)
                    instret <= instret + 16'd1;
            end
        end
    end

    // Controls come straight from state so they collapse the moment reset hits.
    assign imem_addr  = pc;
    assign halted     = (state == HALT);
    assign reg_write  = in_exec & dec.is_alu;
    assign select_imm = in_exec & dec.select_imm;
    assign alu_op     = in_exec ? dec.alu_op : 3'd0;
    assign rs         = in_exec ? dec.rs : 3'd0;
    assign rt         = in_exec ? dec.rt : 3'd0;
    assign rd         = in_exec ? dec.rd : 3'd0;
    assign immidiate  = in_exec ? dec.imm : 6'd0;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: synchronous imem model, ISA-level reference model,
// directed program scenarios followed by random programs.
module tb_fetch_control;

  localparam int PC_W  = 8;
  localparam int MEM_N = 1 << PC_W;

  logic            clk;
  logic            reset;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            carry;
  logic            overflow;
  logic            zero;
  logic [5:0]      immidiate;
  logic            select_imm;
  logic [2:0]      rs;
  logic [2:0]      rt;
  logic [2:0]      rd;
  logic [2:0]      alu_op;
  logic            reg_write;
  logic            halted;
  logic            illegal;
  logic [15:0]     instret;

  fetch_control #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .carry      (carry),
    .overflow   (overflow),
    .zero       (zero),
    .immidiate  (immidiate),
    .select_imm (select_imm),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .halted     (halted),
    .illegal    (illegal),
    .instret    (instret)
  );

  // clock / memory
  logic [15:0] mem [0:MEM_N-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  // scoreboard and reference state
  int          errors = 0;
  int          checks = 0;
  logic [19:0] exp_q[$];
  int          m_pc;
  int          m_instret;
  bit          m_c, m_v, m_z;
  bit          m_halted;
  bit          m_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] obs_ctl();
    return {reg_write, select_imm, alu_op, rs, rt, rd, immidiate};
  endfunction

  // Expected datapath controls for an instruction while it executes.
  function automatic logic [19:0] model_ctl(input logic [15:0] instr);
    int w;
    int op;
    w  = int'(instr);
    op = w >> 12;
    if (op >= 8)
      return {1'b1, 1'b1, 3'(op % 8), 3'((w >> 9) % 8), 3'd0, 3'((w >> 6) % 8), 6'(w % 64)};
    else if (op == 1)
      return {1'b1, 1'b0, 3'(w % 8), 3'((w >> 9) % 8), 3'((w >> 6) % 8), 3'((w >> 3) % 8), 6'd0};
    else
      return 20'd0;
  endfunction

  // Architectural effect of retiring one instruction.
  task automatic model_retire(input logic [15:0] instr, input logic [2:0] cvz);
    int w;
    int op;
    int off;
    int nxt;
    w   = int'(instr);
    op  = w >> 12;
    nxt = (m_pc + 1) % MEM_N;
    if ((op == 2 && m_z) || (op == 3 && m_c) || (op == 4 && m_v)) begin
      off = w % 256;
      if (off >= 128) off = off - 256;
      nxt = (m_pc + 1 + off + MEM_N) % MEM_N;
    end
    if (op == 5) nxt = w % MEM_N;
    if (op == 6) begin
      m_halted = 1'b1;
      nxt      = m_pc;
    end
    if (op == 7) m_illegal = 1'b1;
    if (op == 1 || op >= 8) begin
      m_c = cvz[2];
      m_v = cvz[1];
      m_z = cvz[0];
    end
    if (m_instret < 65535) m_instret++;
    m_pc = nxt;
  endtask

  task automatic model_reset();
    m_pc      = 0;
    m_instret = 0;
    m_c       = 1'b0;
    m_v       = 1'b0;
    m_z       = 1'b0;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
  endtask

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'h0000;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 32'(imem_addr), 32'(m_pc));
    check({tag, "_ctl"}, 32'(obs_ctl()), 32'd0);
    check({tag, "_instret"}, 32'(instret), 32'(m_instret));
    check({tag, "_halted"}, 32'(halted), 32'(m_halted));
    check({tag, "_illegal"}, 32'(illegal), 32'(m_illegal));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    carry    = 1'b0;
    overflow = 1'b0;
    zero     = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
  endtask

  // Called at the falling edge of a FETCH cycle; returns at the falling edge
  // of the cycle after EXEC.
  task automatic step(input logic [2:0] cvz);
    logic [15:0] instr;
    check_idle("fetch");
    @(posedge clk);
    @(negedge clk);
    instr = mem[m_pc];
    exp_q.push_back(model_ctl(instr));
    check("exec_addr", 32'(imem_addr), 32'(m_pc));
    check("exec_ctl", 32'(obs_ctl()), 32'(exp_q.pop_front()));
    {carry, overflow, zero} = cvz;
    model_retire(instr, cvz);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_halt_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("halt_addr", 32'(imem_addr), 32'(m_pc));
      check("halt_rw", 32'(reg_write), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] w;
    reset     = 1'b1;
    carry     = 1'b0;
    overflow  = 1'b0;
    zero      = 1'b0;
    imem_data = 16'h0000;
    clear_mem();
    model_reset();

    // ALU-I decode and first retirement
    clear_mem();
    mem[0] = 16'h8245;
    do_reset();
    step(3'b000);
    check("alui_pc", 32'(imem_addr), 32'd1);
    check("alui_instret", 32'(instret), 32'd1);

    // ALU-R decode, controls idle in FETCH
    clear_mem();
    mem[0] = 16'h14E1;
    do_reset();
    step(3'b000);
    check("alur_fetch_ctl", 32'(obs_ctl()), 32'd0);

    // BZ taken after ALU with zero=1, across an intervening NOP; then not taken
    clear_mem();
    mem[3] = 16'h8000;
    mem[5] = 16'h20FD;
    do_reset();
    for (int i = 0; i < 3; i++) step(3'b000);
    step(3'b001);
    step(3'b000);
    step(3'b000);
    check("bz_taken_pc", 32'(imem_addr), 32'd3);
    step(3'b000);
    step(3'b111);
    step(3'b000);
    check("bz_not_taken_pc", 32'(imem_addr), 32'd6);

    // JMP to the top of the address space, then wrap on PC+1
    clear_mem();
    mem[10] = 16'h50FF;
    do_reset();
    for (int i = 0; i < 11; i++) step(3'($urandom_range(0, 7)));
    check("jmp_pc", 32'(imem_addr), 32'd255);
    step(3'b000);
    check("wrap_pc", 32'(imem_addr), 32'd0);

    // reserved opcode then HALT
    clear_mem();
    mem[0] = 16'h7000;
    mem[1] = 16'h6000;
    do_reset();
    step(3'b000);
    check("illegal_set", 32'(illegal), 32'd1);
    step(3'b000);
    check("illegal_sticky", 32'(illegal), 32'd1);
    check_halt_hold(20);

    // reset in the middle of an ALU EXEC; stored Z must be cleared as well
    clear_mem();
    mem[0] = 16'h8000;
    mem[1] = 16'h8000;
    do_reset();
    step(3'b001);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_rw", 32'(reg_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rw", 32'(reg_write), 32'd0);
    check("async_pc", 32'(imem_addr), 32'd0);
    check("async_instret", 32'(instret), 32'd0);
    check("async_halted", 32'(halted), 32'd0);
    mem[0] = 16'h2005;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(3'b000);
    check("flags_cleared_pc", 32'(imem_addr), 32'd1);

    // random programs without HALT
    for (int i = 0; i < MEM_N; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h6) w[15:12] = 4'h0;
      mem[i] = w;
    end
    do_reset();
    for (int i = 0; i < 400; i++) step(3'($urandom_range(0, 7)));

    // random program that may halt
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 200 && !m_halted; i++) step(3'($urandom_range(0, 7)));
    if (m_halted) check_halt_hold(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
